// File: rtl/rggen_bit_field_counter_if.sv
// Software access bundle between a register block and one bit field.
// Ports: valid/read_mask/write_mask/write_data in; read_data/value out.
interface rggen_bit_field_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic [WIDTH-1:0] read_mask;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport master (
    output valid, read_mask, write_mask, write_data,
    input  read_data, value
  );

  modport bit_field (
    input  valid, read_mask, write_mask, write_data,
    output read_data, value
  );
endinterface

// File: rtl/rggen_bit_field_counter.sv
// Up/down counter bit field: clear > SW write > read-clear > count.
// Ports: i_clk, i_rst (sync, high), bit_field_if, i_enable, i_up,
//   i_up_step, i_down, i_down_step, i_clear, o_value, o_overflow,
//   o_underflow; with RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN also
//   i_threshold and sticky o_threshold_hit.
module rggen_bit_field_counter #(
  parameter int               WIDTH         = 16,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
  parameter int               STEP_WIDTH    = 1,
  parameter bit               SATURATE      = 1'b1,
  parameter bit               SW_READ_CLEAR = 1'b0
)(
  input  logic                  i_clk,
  input  logic                  i_rst,
  rggen_bit_field_if.bit_field  bit_field_if,
  input  logic                  i_enable,
  input  logic                  i_up,
  input  logic [STEP_WIDTH-1:0] i_up_step,
  input  logic                  i_down,
  input  logic [STEP_WIDTH-1:0] i_down_step,
  input  logic                  i_clear,
  output logic [WIDTH-1:0]      o_value,
  output logic                  o_overflow,
  output logic                  o_underflow
`ifdef RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN
  ,
  input  logic [WIDTH-1:0]      i_threshold,
  output logic                  o_threshold_hit
`endif
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("WIDTH out of range");
  end
  if (STEP_WIDTH < 1 || STEP_WIDTH > WIDTH) begin : g_bad_step
    $error("STEP_WIDTH out of range");
  end

  localparam int PAD = WIDTH + 2 - STEP_WIDTH;

  logic [WIDTH-1:0]        value_q;
  logic [WIDTH-1:0]        value_d;
  logic                    overflow_q;
  logic                    overflow_d;
  logic                    underflow_q;
  logic                    underflow_d;

  logic                    sw_write;
  logic                    sw_rclr;
  logic                    do_count;
  logic signed [WIDTH+1:0] up_amt;
  logic signed [WIDTH+1:0] dn_amt;
  logic signed [WIDTH+1:0] sum;
  logic                    ovf;
  logic                    unf;

  // Events made mutually exclusive so the decoder below is one-hot.
  always_comb begin
    sw_write = bit_field_if.valid
             && (bit_field_if.write_mask != '0)
             && !i_clear;
    sw_rclr  = SW_READ_CLEAR
             && bit_field_if.valid
             && (bit_field_if.read_mask != '0)
             && !i_clear && !sw_write;
    do_count = i_enable && !i_clear && !sw_write && !sw_rclr;
  end

  // Sum in WIDTH+2 signed bits: sign bit marks underflow,
  // bit WIDTH set on a non-negative sum marks overflow.
  always_comb begin
    up_amt = '0;
    dn_amt = '0;
    if (i_up) begin
      up_amt = {{PAD{1'b0}}, i_up_step};
    end
    if (i_down) begin
      dn_amt = {{PAD{1'b0}}, i_down_step};
    end
    sum = $signed({2'b00, value_q}) + up_amt - dn_amt;
    unf = sum[WIDTH+1];
    ovf = !sum[WIDTH+1] && sum[WIDTH];
  end

  always_comb begin
    value_d     = value_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    unique case (1'b1)
      i_clear: begin
        value_d = '0;
      end
      sw_write: begin
        value_d = (value_q & ~bit_field_if.write_mask)
                | (bit_field_if.write_data & bit_field_if.write_mask);
      end
      sw_rclr: begin
        value_d = '0;
      end
      do_count: begin
        if (ovf) begin
          overflow_d = 1'b1;
          value_d    = SATURATE ? '1 : sum[WIDTH-1:0];
        end else if (unf) begin
          underflow_d = 1'b1;
          value_d     = SATURATE ? '0 : sum[WIDTH-1:0];
        end else begin
          value_d = sum[WIDTH-1:0];
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      value_q     <= INITIAL_VALUE;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      value_q     <= value_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN
  logic threshold_hit_q;
  logic threshold_hit_d;

  // Clear and SW write drop the flag even if the new value is above.
  always_comb begin
    if (i_clear || sw_write) begin
      threshold_hit_d = 1'b0;
    end else begin
      threshold_hit_d = threshold_hit_q || (value_d >= i_threshold);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      threshold_hit_q <= 1'b0;
    end else begin
      threshold_hit_q <= threshold_hit_d;
    end
  end

  assign o_threshold_hit = threshold_hit_q;
`endif

  assign o_value                = value_q;
  assign o_overflow             = overflow_q;
  assign o_underflow            = underflow_q;
  assign bit_field_if.read_data = value_q;
  assign bit_field_if.value     = value_q;

endmodule

// File: tb/tb_rggen_bit_field_counter.sv
// Bench for rggen_bit_field_counter: saturating and wrapping/read-clear
// instances, reference model compared every cycle plus literal checks.
module tb_rggen_bit_field_counter;

  typedef struct {
    logic       rst, clr, en, up, dn, valid;
    logic [3:0] us, ds;
    logic [7:0] rm, wm, wd;
  } in_t;

  typedef struct {
    int v;
    bit ov, un, th;
  } mst_t;

  logic clk;
  in_t  stim;
  mst_t ma, mb;
  bit   mvalid;
  int   checks;
  int   errors;

  logic [7:0] a_value, b_value;
  logic       a_ovf, a_unf, b_ovf, b_unf;
  logic       a_th, b_th;

  rggen_bit_field_if #(.WIDTH(8)) bif_a ();
  rggen_bit_field_if #(.WIDTH(8)) bif_b ();

  assign bif_a.valid      = stim.valid;
  assign bif_a.read_mask  = stim.rm;
  assign bif_a.write_mask = stim.wm;
  assign bif_a.write_data = stim.wd;
  assign bif_b.valid      = stim.valid;
  assign bif_b.read_mask  = stim.rm;
  assign bif_b.write_mask = stim.wm;
  assign bif_b.write_data = stim.wd;

  rggen_bit_field_counter #(
    .WIDTH(8), .INITIAL_VALUE(8'h5A), .STEP_WIDTH(4),
    .SATURATE(1'b1), .SW_READ_CLEAR(1'b0)
  ) dut_a (
    .i_clk(clk), .i_rst(stim.rst), .bit_field_if(bif_a),
    .i_enable(stim.en), .i_up(stim.up), .i_up_step(stim.us),
    .i_down(stim.dn), .i_down_step(stim.ds), .i_clear(stim.clr),
    .o_value(a_value), .o_overflow(a_ovf), .o_underflow(a_unf)
`ifdef RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN
    , .i_threshold(8'h20), .o_threshold_hit(a_th)
`endif
  );

  rggen_bit_field_counter #(
    .WIDTH(8), .INITIAL_VALUE(8'h00), .STEP_WIDTH(4),
    .SATURATE(1'b0), .SW_READ_CLEAR(1'b1)
  ) dut_b (
    .i_clk(clk), .i_rst(stim.rst), .bit_field_if(bif_b),
    .i_enable(stim.en), .i_up(stim.up), .i_up_step(stim.us),
    .i_down(stim.dn), .i_down_step(stim.ds), .i_clear(stim.clr),
    .o_value(b_value), .o_overflow(b_ovf), .o_underflow(b_unf)
`ifdef RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN
    , .i_threshold(8'h80), .o_threshold_hit(b_th)
`endif
  );

`ifndef RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN
  assign a_th = 1'b0;
  assign b_th = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mst_t mnext(mst_t s, in_t i, bit sat, bit rc,
                                 int init, int thr);
    mst_t n;
    int   r;
    bit   wr_, rd_;
    n    = s;
    n.ov = 0;
    n.un = 0;
    wr_  = i.valid && (i.wm != 0);
    rd_  = rc && i.valid && (i.rm != 0);
    if (i.rst) begin
      n.v  = init;
      n.th = 0;
      return n;
    end
    if (i.clr) n.v = 0;
    else if (wr_)
      n.v = (s.v & ~int'(i.wm)) | (int'(i.wd) & int'(i.wm));
    else if (rd_) n.v = 0;
    else if (i.en) begin
      r = s.v + (i.up ? int'(i.us) : 0) - (i.dn ? int'(i.ds) : 0);
      if (r > 255) begin
        n.ov = 1;
        n.v  = sat ? 255 : r - 256;
      end else if (r < 0) begin
        n.un = 1;
        n.v  = sat ? 0 : r + 256;
      end else begin
        n.v = r;
      end
    end
    if (i.clr || wr_) n.th = 0;
    else n.th = s.th || (n.v >= thr);
    return n;
  endfunction

  always @(posedge clk) begin
    ma <= mnext(ma, stim, 1'b1, 1'b0, 'h5A, 'h20);
    mb <= mnext(mb, stim, 1'b0, 1'b1, 'h00, 'h80);
    if (stim.rst) mvalid <= 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_a_value", int'(a_value), ma.v);
      chk("m_a_rdata", int'(bif_a.read_data), ma.v);
      chk("m_a_ifval", int'(bif_a.value), ma.v);
      chk("m_a_ovf", int'(a_ovf), int'(ma.ov));
      chk("m_a_unf", int'(a_unf), int'(ma.un));
      chk("m_b_value", int'(b_value), mb.v);
      chk("m_b_rdata", int'(bif_b.read_data), mb.v);
      chk("m_b_ovf", int'(b_ovf), int'(mb.ov));
      chk("m_b_unf", int'(b_unf), int'(mb.un));
`ifdef RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN
      chk("m_a_th", int'(a_th), int'(ma.th));
      chk("m_b_th", int'(b_th), int'(mb.th));
`endif
    end
  end

  task automatic cyc(input logic rst, clr, en, up,
                     input logic [3:0] us, input logic dn,
                     input logic [3:0] ds, input logic valid,
                     input logic [7:0] rm, wm, wd);
    stim.rst   = rst;
    stim.clr   = clr;
    stim.en    = en;
    stim.up    = up;
    stim.us    = us;
    stim.dn    = dn;
    stim.ds    = ds;
    stim.valid = valid;
    stim.rm    = rm;
    stim.wm    = wm;
    stim.wd    = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [7:0] d, input logic [7:0] m);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, m, d);
  endtask

  task automatic count(input logic en, up, input logic [3:0] us,
                       input logic dn, input logic [3:0] ds);
    cyc(0, 0, en, up, us, dn, ds, 0, 0, 0, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mvalid = 0;
    ma     = '{0, 0, 0, 0};
    mb     = '{0, 0, 0, 0};
    stim   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    @(negedge clk);

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_a_value", int'(a_value), 'h5A);
    chk("rst_b_value", int'(b_value), 'h00);
    chk("rst_a_ovf", int'(a_ovf), 0);
    chk("rst_a_unf", int'(a_unf), 0);

    wr(8'hFE, 8'hFF);
    chk("wr_a_fe", int'(a_value), 'hFE);
    count(1, 1, 3, 0, 0);
    chk("sat_a_ff", int'(a_value), 'hFF);
    chk("sat_a_ovf", int'(a_ovf), 1);
    chk("wrap_b_01", int'(b_value), 'h01);
    chk("wrap_b_ovf", int'(b_ovf), 1);
    count(1, 1, 3, 0, 0);
    chk("sat_hold_ff", int'(a_value), 'hFF);
    chk("sat_hold_ovf", int'(a_ovf), 1);
    chk("b_04_noovf", int'(b_ovf), 0);
    idle();
    chk("ovf_pulse_end", int'(a_ovf), 0);

    wr(8'h01, 8'hFF);
    count(1, 0, 0, 1, 3);
    chk("unf_a_00", int'(a_value), 'h00);
    chk("unf_a_pulse", int'(a_unf), 1);
    chk("unf_b_fe", int'(b_value), 'hFE);
    chk("unf_b_pulse", int'(b_unf), 1);
    idle();
    chk("unf_pulse_end", int'(b_unf), 0);

    wr(8'h10, 8'hFF);
    count(1, 1, 2, 1, 2);
    chk("net_zero_val", int'(a_value), 'h10);
    chk("net_zero_ovf", int'(a_ovf), 0);
    chk("net_zero_unf", int'(a_unf), 0);
    count(0, 1, 5, 0, 0);
    chk("en_off_val", int'(a_value), 'h10);

    wr(8'h30, 8'hFF);
    cyc(0, 0, 1, 1, 1, 0, 0, 1, 0, 8'h0F, 8'hA5);
    chk("wr_wins_a", int'(a_value), 'h35);
    chk("wr_wins_b", int'(b_value), 'h35);
    cyc(0, 1, 1, 1, 1, 0, 0, 1, 0, 8'h0F, 8'hA5);
    chk("clr_wins_a", int'(a_value), 'h00);

    wr(8'h42, 8'hFF);
    chk("rc_rdata_b", int'(bif_b.read_data), 'h42);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 8'hFF, 0, 0);
    chk("rc_b_cleared", int'(b_value), 'h00);
    chk("rc_a_kept", int'(a_value), 'h42);

    wr(8'h1F, 8'hFF);
`ifdef RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN
    chk("th_below", int'(a_th), 0);
`endif
    count(1, 1, 1, 0, 0);
    chk("th_val_20", int'(a_value), 'h20);
`ifdef RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN
    chk("th_set", int'(a_th), 1);
`endif
    count(1, 1, 1, 0, 0);
    idle();
`ifdef RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN
    chk("th_held", int'(a_th), 1);
`endif

    cyc(1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("midrst_a", int'(a_value), 'h5A);
    chk("midrst_b", int'(b_value), 'h00);
    chk("midrst_ovf", int'(a_ovf), 0);
`ifdef RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN
    chk("midrst_th", int'(a_th), 0);
`endif
    count(1, 1, 1, 0, 0);
    chk("resume_a", int'(a_value), 'h5B);
    chk("resume_b", int'(b_value), 'h01);

    for (int k = 0; k < 400; k++) begin
      logic       r_rst, r_clr, r_en, r_up, r_dn, r_v;
      logic [3:0] r_us, r_ds;
      logic [7:0] r_rm, r_wm, r_wd;
      r_rst = ($urandom_range(63) == 0);
      r_clr = ($urandom_range(15) == 0);
      r_en  = ($urandom_range(3) != 0);
      r_up  = 1'($urandom_range(1));
      r_dn  = 1'($urandom_range(1));
      r_us  = 4'($urandom_range(15));
      r_ds  = 4'($urandom_range(15));
      r_v   = ($urandom_range(7) == 0);
      r_rm  = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
      r_wm  = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
      r_wd  = 8'($urandom);
      cyc(r_rst, r_clr, r_en, r_up, r_us, r_dn, r_ds,
          r_v, r_rm, r_wm, r_wd);
    end

    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rggen_bit_field_counter.md
RGGEN_BIT_FIELD_COUNTER -- requirements
Module: rggen_bit_field_counter

Interface
REQ-001 Parameter WIDTH SHALL default to 16 and set counter width in bits (1..64).
REQ-002 Parameter INITIAL_VALUE SHALL default to '0 and set the counter value loaded on reset.
REQ-003 Parameter STEP_WIDTH SHALL default to 1 and set the width of the up/down step inputs (1..WIDTH); elaboration SHALL fail if out of range.
REQ-004 Parameter SATURATE SHALL default to 1; 1 clamps at bounds, 0 wraps modulo 2^WIDTH.
REQ-005 Parameter SW_READ_CLEAR SHALL default to 0; 1 clears the counter on a software read access.
REQ-006 Port i_clk  input  1  clock; all state updates on its rising edge.
REQ-007 Port i_rst  input  1  synchronous, active-high reset.
REQ-008 Port bit_field_if  modport rggen_bit_field_if.bit_field  -  software access: valid, read_mask, write_mask, write_data in; read_data, value out.
REQ-009 Port i_enable  input  1  count enable; gates i_up/i_down only.
REQ-010 Port i_up  input  1  increment request.
REQ-011 Port i_up_step  input  STEP_WIDTH  increment amount.
REQ-012 Port i_down  input  1  decrement request.
REQ-013 Port i_down_step  input  STEP_WIDTH  decrement amount.
REQ-014 Port i_clear  input  1  hardware clear request.
REQ-015 Port i_threshold  input  WIDTH  compare threshold (present only with RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN).
REQ-016 Port o_value  output  WIDTH  current counter value.
REQ-017 Port o_overflow  output  1  one-cycle pulse on upper-bound crossing.
REQ-018 Port o_underflow  output  1  one-cycle pulse on lower-bound crossing.
REQ-019 Port o_threshold_hit  output  1  sticky threshold flag (present only with the macro).

Function
REQ-020 bit_field_if.read_data, bit_field_if.value and o_value SHALL all equal the counter register, no combinational path from inputs.
REQ-021 Update priority per cycle SHALL be: i_clear > SW write (valid && write_mask!='0) > SW read-clear (SW_READ_CLEAR && valid && read_mask!='0) > count.
REQ-022 i_clear SHALL load 0 at the next edge.
REQ-023 SW write SHALL load (value & ~write_mask) | (write_data & write_mask) at the next edge.
REQ-024 Count SHALL occur only when i_enable=1 and no higher-priority event; delta = (i_up ? i_up_step : 0) - (i_down ? i_down_step : 0), both evaluated in the same cycle (i_up and i_down together net out).
REQ-025 Sum SHALL be computed signed in WIDTH+2 bits; result > 2^WIDTH-1 is overflow, result < 0 is underflow.
REQ-026 On overflow: SATURATE=1 loads all-ones, SATURATE=0 loads result mod 2^WIDTH; o_overflow SHALL pulse high the cycle after (registered), exactly one cycle.
REQ-027 On underflow: SATURATE=1 loads 0, SATURATE=0 loads result mod 2^WIDTH; o_underflow SHALL pulse the cycle after, exactly one cycle.
REQ-028 Saturated counter receiving further up-steps SHALL hold and pulse o_overflow each such cycle.
REQ-029 Zero delta (no request, or equal up/down steps) SHALL leave the value and flags unchanged.
REQ-030 o_overflow/o_underflow SHALL never assert on clear, SW write or read-clear cycles.

Reset
REQ-031 i_rst high at a rising edge SHALL load INITIAL_VALUE and drive o_overflow, o_underflow, o_threshold_hit to 0, overriding every other input.
REQ-032 Reset asserted mid-count SHALL discard the in-flight update; counting resumes the first edge after i_rst deasserts.

Configuration
REQ-033 With RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN defined, o_threshold_hit SHALL set on the edge where the new value >= i_threshold and stay set until i_clear or a SW write clears it (clear wins over set in the same cycle).
REQ-034 Without RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN, i_threshold and o_threshold_hit SHALL be absent and no compare logic synthesised.

Verification
REQ-035 WIDTH=8, SATURATE=1, value 0xFE, i_up step 3 -> value 0xFF, o_overflow one-cycle pulse; next up cycle -> 0xFF, pulse again.
REQ-036 WIDTH=8, SATURATE=0, value 0x01, i_down step 3 -> value 0xFE, o_underflow pulse.
REQ-037 value 0x10, i_up step 2 and i_down step 2 together -> value 0x10, no pulses; i_enable=0 with i_up -> no change.
REQ-038 SW write 0xA5 mask 0x0F on value 0x30 with i_up and i_clear=0 -> 0x35 (write wins); same cycle with i_clear=1 -> 0x00.
REQ-039 SW_READ_CLEAR=1, read access at value 0x42 -> read_data 0x42 that cycle, value 0x00 next.
REQ-040 Macro defined, threshold 0x20, count from 0x1F by 1 -> o_threshold_hit set at 0x20 and held; i_rst mid-sequence -> INITIAL_VALUE, all flags 0.
